// File: rtl/reg_pkg.sv
// Shared definitions for the parameterised register bank: operation codes
// and the half-width helper used to split each register into two halves.
package reg_pkg;

  typedef enum logic [2:0] {
    FUN_DEC   = 3'b000,
    FUN_INC   = 3'b001,
    FUN_LOAD  = 3'b010,
    FUN_CLR   = 3'b011,
    FUN_LO_ZX = 3'b100,
    FUN_LO    = 3'b101,
    FUN_HI    = 3'b110,
    FUN_LO_SX = 3'b111
  } fun_e;

  function automatic int half_width(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/register_cell.sv
// One WIDTH-bit register applying a FunSel operation when enabled; wrap flags
// that the operation about to be applied at this edge rolls the value over.
module register_cell
  import reg_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             wrap
);

  localparam int H = half_width(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] nxt;
  logic [H-1:0]     i_lo;

  assign i_lo = I[H-1:0];

  always_comb begin
    nxt = Q;
    case (FunSel)
      FUN_DEC:   nxt = Q - ONE;
      FUN_INC:   nxt = Q + ONE;
      FUN_LOAD:  nxt = I;
      FUN_CLR:   nxt = '0;
      FUN_LO_ZX: nxt = {{H{1'b0}}, i_lo};
      FUN_LO:    nxt = {Q[WIDTH-1:H], i_lo};
      FUN_HI:    nxt = {i_lo, Q[H-1:0]};
      FUN_LO_SX: nxt = {{H{i_lo[H-1]}}, i_lo};
      default:   nxt = Q;
    endcase
  end

  // Combinational look-ahead; the bank registers the OR of all cells.
  assign wrap = E & (((FunSel == FUN_INC) & (&Q)) |
                     ((FunSel == FUN_DEC) & ~(|Q)));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Q <= RST_VAL;
    end else if (E) begin
      Q <= nxt;
    end
  end

endmodule

// File: rtl/param_register_bank.sv
// Bank of NREG register cells sharing one operation code, with two
// combinational read ports, a zero flag on port A and a registered wrap pulse.
module param_register_bank
  import reg_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter int               NREG    = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [WIDTH-1:0]        I,
  input  logic                    E,
  input  logic [NREG-1:0]         RegSel,
  input  logic [2:0]              FunSel,
  input  logic [$clog2(NREG)-1:0] OutASel,
  input  logic [$clog2(NREG)-1:0] OutBSel,
  output logic [WIDTH-1:0]        OutA,
  output logic [WIDTH-1:0]        OutB,
  output logic                    ZeroA,
  output logic                    Wrap
);

  localparam int SELW = $clog2(NREG);

  logic [WIDTH-1:0] q [NREG];
  logic [NREG-1:0]  cell_wrap;

  for (genvar k = 0; k < NREG; k++) begin : g_cell
    register_cell #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .Clock  (Clock),
      .Reset  (Reset),
      .E      (E & RegSel[k]),
      .FunSel (FunSel),
      .I      (I),
      .Q      (q[k]),
      .wrap   (cell_wrap[k])
    );
  end

  // Indices past the last register fall through to zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NREG; k++) begin
      if (SELW'(k) == OutASel) OutA = q[k];
      if (SELW'(k) == OutBSel) OutB = q[k];
    end
  end

  assign ZeroA = (OutA == '0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Wrap <= 1'b0;
    end else begin
      Wrap <= |cell_wrap;
    end
  end

endmodule

// File: doc/param_register_bank.md
PARAM_REGISTER_BANK -- requirements
Module: param_register_bank

Interface
REQ-001 Parameter WIDTH, default 16, register width in bits; SHALL be even and at least 4.
REQ-002 Parameter NREG, default 4, number of registers; SHALL be at least 2.
REQ-003 Parameter RST_VAL, default 0, WIDTH-bit value loaded into every register on reset.
REQ-004 Clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 Reset  input  1  reset; asynchronous, active-low.
REQ-006 I  input  WIDTH  write data.
REQ-007 E  input  1  global enable; when 0, no register SHALL change.
REQ-008 RegSel  input  NREG  one-hot-or-more write mask; bit k selects register k.
REQ-009 FunSel  input  3  operation code applied to every selected register.
REQ-010 OutASel, OutBSel  input  clog2(NREG)  read-port register indices.
REQ-011 OutA, OutB  output  WIDTH  read-port data.
REQ-012 ZeroA  output  1  high when OutA equals 0.
REQ-013 Wrap  output  1  registered wrap pulse from increment or decrement.

Function
REQ-014 H = WIDTH/2; "low half" is bits H-1:0 and "high half" is bits WIDTH-1:H.
REQ-015 When E=1, each register k with RegSel[k]=1 SHALL apply the FunSel operation at the clock edge; unselected registers SHALL hold.
REQ-016 FunSel encoding:
  000 = decrement, modulo 2^WIDTH.
  001 = increment, modulo 2^WIDTH.
  010 = load I.
  011 = clear to 0.
  100 = high half <= 0, low half <= I low half.
  101 = low half <= I low half; high half held.
  110 = high half <= I low half; low half held.
  111 = low half <= I low half; high half filled with I[H-1] (full sign extension over all H bits).
REQ-017 Reads SHALL be combinational with zero latency: OutA = reg[OutASel] and OutB = reg[OutBSel], independent of E.
REQ-018 A read of a register written in the same cycle SHALL return the pre-edge value; the new value SHALL appear after the edge. There is no write-through bypass.
REQ-019 An index >= NREG (possible when NREG is not a power of 2) SHALL read as 0.
REQ-020 ZeroA SHALL be combinational from OutA.
REQ-021 Wrap SHALL be 1 for exactly the cycle after an edge at which any selected register went all-ones -> 0 on increment, or 0 -> all-ones on decrement. Otherwise Wrap SHALL be 0.
REQ-022 Multiple selected registers SHALL each apply the operation independently; their wrap conditions SHALL be ORed into Wrap.
REQ-023 RegSel = 0 or E = 0 SHALL hold all registers and drive Wrap to 0 on the next edge.
REQ-024 Both read ports MAY select the same register, and both SHALL return identical data.

Reset
REQ-025 Reset low SHALL immediately set every register to RST_VAL and Wrap to 0, without waiting for Clock.
REQ-026 While Reset is low, writes SHALL be ignored; a reset asserted mid-operation SHALL discard any in-flight operation.
REQ-027 The first edge after Reset deasserts SHALL perform a normal operation.

Structure
REQ-028 The FunSel codes SHALL be defined as named constants in a shared package, reg_pkg, together with the H derivation helper.
REQ-029 One sub-module, register_cell, SHALL implement a single WIDTH-bit register with E, FunSel, I and a wrap output.
REQ-030 param_register_bank SHALL instantiate NREG copies of register_cell and contain the read multiplexers, the ZeroA logic and the Wrap register.

Verification
REQ-031 Reset: assert Reset low mid-cycle with RST_VAL=16'h00A5 -> all registers read 16'h00A5 immediately and Wrap=0.
REQ-032 Increment wrap: reg1=16'hFFFF, RegSel=0010, FunSel=001, E=1 -> reg1=16'h0000, Wrap=1 for one cycle, ZeroA=1 with OutASel=1.
REQ-033 Sign extension: I=16'h3480, FunSel=111, RegSel=0001 -> reg0=16'hFF80; I=16'h347F -> reg0=16'h007F.
REQ-034 Half writes: reg2=16'h1234, FunSel=110, I=16'h00AB -> reg2=16'hAB34; then FunSel=101, I=16'h00CD -> reg2=16'hABCD.
REQ-035 Multi-select and hold: RegSel=1111, FunSel=000 with all registers 0 -> all read 16'hFFFF and Wrap=1; then E=0 with FunSel=010 -> no change.
REQ-036 Same-cycle read: OutASel=3, load I=16'h5555 into reg3 -> OutA shows the old value before the edge and 16'h5555 after it; also rerun with WIDTH=8, NREG=3 and OutASel=3 -> OutA=0.
